// File: rtl/mtl2_vid_rx.sv
// mtl2_vid_rx: clocked-video receiver. Registers the parallel RGB video bus,
// frames it on V-sync rising edges and repacks each frame into an Avalon-ST
// video packet (header beat + H_ACTIVE*V_ACTIVE pixels) through a small
// show-ahead FIFO that absorbs downstream backpressure.
module mtl2_vid_rx #(
    parameter int H_ACTIVE   = 800,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        vid_clk,
    input  logic        reset,
    input  logic [23:0] vid_data,
    input  logic        vid_datavalid,
    input  logic        vid_v_sync,
    input  logic        vid_h_sync,
    output logic [23:0] dout_data,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        dout_startofpacket,
    output logic        dout_endofpacket,
    output logic        overflow,
    output logic        frame_err
);

    localparam int TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(TOTAL - 1);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {
        WAIT_VS  = 1'b0,
        IN_FRAME = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input stage
    // ------------------------------------------------------------------
    logic [23:0] data_reg;
    logic        dv_reg;
    logic        vs_reg;
    logic        vs_prev_reg;
    logic        hs_reg;
    logic        vs_rise;

    // Register every video input once; keep last V-sync for edge detection.
    always_ff @(posedge vid_clk) begin
        if (reset) begin
            data_reg    <= '0;
            dv_reg      <= 1'b0;
            vs_reg      <= 1'b0;
            vs_prev_reg <= 1'b0;
            hs_reg      <= 1'b0;
        end else begin
            data_reg    <= vid_data;
            dv_reg      <= vid_datavalid;
            vs_reg      <= vid_v_sync;
            vs_prev_reg <= vs_reg;
            hs_reg      <= vid_h_sync;
        end
    end

    assign vs_rise = vs_reg & ~vs_prev_reg;

    // H-sync is captured for observability only; packing ignores it.
    logic unused_hs;
    assign unused_hs = hs_reg;

    // ------------------------------------------------------------------
    // Show-ahead FIFO, entry = {sop, eop, data}
    // ------------------------------------------------------------------
    logic [25:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             fifo_full;
    logic             wr_req;
    logic [25:0]      wr_word;
    logic             wr_en;
    logic             rd_en;
    logic [25:0]      head;

    // Full is judged before any same-cycle read, so a write into a full
    // FIFO is dropped even when the head is being consumed.
    assign fifo_full = (count_reg == DEPTH_CNT);
    assign wr_en     = wr_req & ~fifo_full;
    assign rd_en     = (count_reg != '0) & dout_ready;

    // Per-entry storage write; entries hold no reset value because the
    // outputs are masked whenever the FIFO is empty.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            always_ff @(posedge vid_clk) begin
                if (wr_en && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem[gi] <= wr_word;
                end
            end
        end
    endgenerate

    // FIFO pointers and occupancy.
    always_ff @(posedge vid_clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head               = mem[rd_ptr_reg];
    assign dout_valid         = (count_reg != '0);
    assign dout_data          = dout_valid ? head[23:0] : 24'h0;
    assign dout_endofpacket   = dout_valid & head[24];
    assign dout_startofpacket = dout_valid & head[25];

    // ------------------------------------------------------------------
    // Framing FSM
    // ------------------------------------------------------------------
    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] pix_cnt_reg;
    logic             cnt_clear;
    logic             cnt_inc;
    logic             frame_err_reg;
    logic             frame_err_next;
    logic             overflow_reg;
    logic             last_pix;

    assign last_pix = (pix_cnt_reg == LAST_PIX);

    // State register.
    always_ff @(posedge vid_clk) begin
        if (reset) state_reg <= WAIT_VS;
        else       state_reg <= state_next;
    end

    // Next state: a dropped header keeps us waiting for the next V-sync;
    // inside a frame either V-sync (early) or the eop pixel ends it.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WAIT_VS: begin
                if (vs_rise && !fifo_full) state_next = IN_FRAME;
            end
            IN_FRAME: begin
                if (vs_rise)                  state_next = WAIT_VS;
                else if (dv_reg && last_pix)  state_next = WAIT_VS;
            end
            default: state_next = WAIT_VS;
        endcase
    end

    // Outputs: FIFO write request/word, counter control, error pulse.
    // A V-sync edge takes priority over a pixel in the same cycle.
    always_comb begin
        wr_req         = 1'b0;
        wr_word        = '0;
        cnt_clear      = 1'b0;
        cnt_inc        = 1'b0;
        frame_err_next = 1'b0;
        case (state_reg)
            WAIT_VS: begin
                if (vs_rise) begin
                    wr_req    = 1'b1;
                    wr_word   = {1'b1, 1'b0, 24'h0};
                    cnt_clear = 1'b1;
                end
            end
            IN_FRAME: begin
                if (vs_rise) begin
                    wr_req         = 1'b1;
                    wr_word        = {1'b0, 1'b1, 24'h0};
                    frame_err_next = 1'b1;
                end else if (dv_reg) begin
                    wr_req  = 1'b1;
                    wr_word = {1'b0, last_pix, data_reg};
                    cnt_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Pixel counter advances on every valid pixel, written or dropped,
    // so eop stays aligned to the frame even after overflow.
    always_ff @(posedge vid_clk) begin
        if (reset)          pix_cnt_reg <= '0;
        else if (cnt_clear) pix_cnt_reg <= '0;
        else if (cnt_inc)   pix_cnt_reg <= pix_cnt_reg + 1'b1;
    end

    // Sticky overflow and one-cycle short-frame pulse.
    always_ff @(posedge vid_clk) begin
        if (reset) begin
            overflow_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            overflow_reg  <= overflow_reg | (wr_req & fifo_full);
            frame_err_reg <= frame_err_next;
        end
    end

    assign overflow  = overflow_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_mtl2_vid_rx.sv
// Testbench for mtl2_vid_rx with a 4x2 frame and a 4-entry FIFO.
// Table-driven cycle vectors for the nominal/short/pre-sync cases, plus
// hand-written sequences for backpressure, mid-frame reset and full-FIFO
// read/write collision.
module tb_mtl2_vid_rx;

    localparam int H = 4;
    localparam int V = 2;
    localparam int D = 4;

    logic        vid_clk = 1'b0;
    logic        reset;
    logic [23:0] vid_data;
    logic        vid_datavalid;
    logic        vid_v_sync;
    logic        vid_h_sync;
    logic [23:0] dout_data;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_startofpacket;
    logic        dout_endofpacket;
    logic        overflow;
    logic        frame_err;

    always #5 vid_clk = ~vid_clk;

    mtl2_vid_rx #(
        .H_ACTIVE  (H),
        .V_ACTIVE  (V),
        .FIFO_DEPTH(D)
    ) dut (
        .vid_clk           (vid_clk),
        .reset             (reset),
        .vid_data          (vid_data),
        .vid_datavalid     (vid_datavalid),
        .vid_v_sync        (vid_v_sync),
        .vid_h_sync        (vid_h_sync),
        .dout_data         (dout_data),
        .dout_valid        (dout_valid),
        .dout_ready        (dout_ready),
        .dout_startofpacket(dout_startofpacket),
        .dout_endofpacket  (dout_endofpacket),
        .overflow          (overflow),
        .frame_err         (frame_err)
    );

    typedef struct {
        logic        vs;
        logic        dv;
        logic [23:0] data;
        logic        ready;
        logic        ev;
        logic [23:0] ed;
        logic        es;
        logic        ee;
        logic        ef;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   nom_first;
    int   nom_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge vid_clk);
        #1;
    endtask

    task automatic drive(input logic vs, input logic dv, input logic [23:0] d, input logic rdy);
        vid_v_sync    = vs;
        vid_datavalid = dv;
        vid_data      = d;
        dout_ready    = rdy;
    endtask

    task automatic add(input logic vs, input logic dv, input logic [23:0] d,
                       input logic ev, input logic [23:0] ed, input logic es,
                       input logic ee, input logic ef);
        vec_t v;
        v.vs = vs; v.dv = dv; v.data = d; v.ready = 1'b1;
        v.ev = ev; v.ed = ed; v.es = es; v.ee = ee; v.ef = ef;
        tbl.push_back(v);
    endtask

    task automatic apply_rows(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            drive(tbl[i].vs, tbl[i].dv, tbl[i].data, tbl[i].ready);
            tick();
            check($sformatf("row%0d valid", i), 32'(dout_valid), 32'(tbl[i].ev));
            check($sformatf("row%0d frame_err", i), 32'(frame_err), 32'(tbl[i].ef));
            check($sformatf("row%0d overflow", i), 32'(overflow), 32'(0));
            if (tbl[i].ev) begin
                check($sformatf("row%0d data", i), 32'(dout_data), 32'(tbl[i].ed));
                check($sformatf("row%0d sop", i), 32'(dout_startofpacket), 32'(tbl[i].es));
                check($sformatf("row%0d eop", i), 32'(dout_endofpacket), 32'(tbl[i].ee));
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " valid"}, 32'(dout_valid), 32'(0));
        check({tag, " data"}, 32'(dout_data), 32'(0));
        check({tag, " sop"}, 32'(dout_startofpacket), 32'(0));
        check({tag, " eop"}, 32'(dout_endofpacket), 32'(0));
        check({tag, " overflow"}, 32'(overflow), 32'(0));
        check({tag, " frame_err"}, 32'(frame_err), 32'(0));
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 24'h0, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        vid_h_sync = 1'b0;
        drive(1'b0, 1'b0, 24'h0, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        check_reset_state("por");
        reset = 1'b0;

        // Pixels before the first V-sync: no writes (rows 0..2).
        add(1'b0, 1'b1, 24'h55, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 24'h56, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 24'h00, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        // Nominal 4x2 frame, pixels 1..8; header appears 2 edges after V-sync.
        nom_first = tbl.size();
        add(1'b1, 1'b0, 24'h0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 24'h1, 1'b1, 24'h0, 1'b1, 1'b0, 1'b0);
        for (int p = 2; p <= 8; p++)
            add(1'b0, 1'b1, 24'(p), 1'b1, 24'(p - 1), 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 24'h0, 1'b1, 24'h8, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 24'h0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        nom_last = tbl.size() - 1;
        // Short frame: 5 pixels, then V-sync with a coincident (ignored) pixel.
        add(1'b1, 1'b0, 24'h0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 24'h1, 1'b1, 24'h0, 1'b1, 1'b0, 1'b0);
        for (int p = 2; p <= 5; p++)
            add(1'b0, 1'b1, 24'(p), 1'b1, 24'(p - 1), 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 24'h99, 1'b1, 24'h5, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 24'h66, 1'b1, 24'h0, 1'b0, 1'b1, 1'b1);
        add(1'b0, 1'b1, 24'h77, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 24'h88, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 24'h00, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        // Resynchronise on the following V-sync.
        add(1'b1, 1'b1, 24'hAA, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 24'hA1, 1'b1, 24'h0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 24'h00, 1'b1, 24'hA1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 24'h00, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);

        apply_rows(0, tbl.size() - 1);

        // Backpressure: whole frame with dout_ready low.
        do_reset();
        drive(1'b1, 1'b0, 24'h0, 1'b0);
        tick();
        for (int p = 1; p <= 8; p++) begin
            drive(1'b0, 1'b1, 24'(p), 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 24'h0, 1'b0);
        tick();
        tick();
        check("bp overflow", 32'(overflow), 32'(1));
        check("bp valid", 32'(dout_valid), 32'(1));
        check("bp head sop", 32'(dout_startofpacket), 32'(1));
        tick();
        check("bp head stable", 32'(dout_data), 32'(0));
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 24'h0, 1'b1);
            check($sformatf("bp drain%0d valid", i), 32'(dout_valid), 32'(1));
            check($sformatf("bp drain%0d data", i), 32'(dout_data), 32'(i));
            check($sformatf("bp drain%0d sop", i), 32'(dout_startofpacket), 32'(i == 0));
            check($sformatf("bp drain%0d eop", i), 32'(dout_endofpacket), 32'(0));
            tick();
        end
        check("bp empty", 32'(dout_valid), 32'(0));
        check("bp overflow sticky", 32'(overflow), 32'(1));

        // Reset mid-frame with 3 beats queued, then a clean frame.
        do_reset();
        drive(1'b1, 1'b0, 24'h0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 24'h1, 1'b0);
        tick();
        drive(1'b0, 1'b1, 24'h2, 1'b0);
        tick();
        drive(1'b0, 1'b0, 24'h0, 1'b0);
        tick();
        check("mid valid before reset", 32'(dout_valid), 32'(1));
        check("mid head before reset", 32'(dout_data), 32'(0));
        reset = 1'b1;
        tick();
        check_reset_state("mid reset");
        reset = 1'b0;
        apply_rows(nom_first, nom_last);

        // Full FIFO with simultaneous read and pixel write.
        do_reset();
        drive(1'b1, 1'b0, 24'h0, 1'b0);
        tick();
        for (int p = 1; p <= 4; p++) begin
            drive(1'b0, 1'b1, 24'(p), 1'b0);
            tick();
        end
        check("full overflow before", 32'(overflow), 32'(0));
        drive(1'b0, 1'b0, 24'h0, 1'b1);
        check("full head hdr", 32'(dout_data), 32'(0));
        tick();
        check("full overflow after", 32'(overflow), 32'(1));
        for (int i = 1; i <= 3; i++) begin
            check($sformatf("full drain%0d valid", i), 32'(dout_valid), 32'(1));
            check($sformatf("full drain%0d data", i), 32'(dout_data), 32'(i));
            tick();
        end
        check("full pixel dropped", 32'(dout_valid), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
